// File: rtl/pix_pkg.sv
// Shared pixel types for the frame reader and its 2-entry output buffer.
package pix_pkg;

   localparam int PIX_W = 24;

   typedef logic [PIX_W-1:0] rgb_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } reader_state_t;

   typedef struct packed {
      rgb_t data;
      logic sof;
      logic eol;
      logic eof;
   } pix_beat_t;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry FIFO of pixel beats; the reader's credit rule guarantees it never overflows.
module pix_fifo2
   import pix_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  logic       pop_i,
   input  pix_beat_t  din_i,
   output pix_beat_t  dout_o,
   output logic [1:0] count_o,
   output logic       full_o,
   output logic       empty_o
);

   pix_beat_t  mem_q [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q ^ push_i;
      rd_ptr_d = rd_ptr_q ^ pop_i;
      count_d  = count_q;
      if (push_i && !pop_i) begin
         count_d = count_q + 2'd1;
      end else if (pop_i && !push_i) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);

   push_when_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && full_o));
   pop_when_empty_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(pop_i && empty_o));

endmodule

// File: rtl/frame_reader.sv
// Raster-scan reader of a 1-cycle-latency frame buffer BRAM onto a valid/ready RGB stream.
// Define FRAME_LOOP_EN to rescan frames back-to-back until stop is requested.
module frame_reader
   import pix_pkg::*;
#(
   parameter int H_PIX  = 320,
   parameter int V_PIX  = 240,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [PIX_W-1:0]  mem_data,
   output logic [PIX_W-1:0]  pix_out,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              sof,
   output logic              eol,
   output logic              eof,
   output logic              busy,
   output logic              done
);

   localparam int X_W = $clog2(H_PIX);
   localparam int Y_W = (V_PIX > 1) ? $clog2(V_PIX) : 1;
   localparam logic [X_W-1:0] X_LAST = X_W'(H_PIX - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_PIX - 1);

   reader_state_t     state_q, state_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              inflight_q;
   logic              done_q, done_d;
   logic [2:0]        flags_q, flags_d;
   logic              issue, pop, credit_ok, last_pix, drained;
   logic [2:0]        occupancy;

   pix_beat_t         push_beat, head_beat;
   logic [1:0]        fifo_count;
   logic              fifo_empty, fifo_full_unused;

`ifdef FRAME_LOOP_EN
   logic              stop_q, stop_d;
`else
   logic              unused_stop;
   assign unused_stop = stop;
`endif

   assign pop       = pix_valid & pix_ready;
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
   // Equivalent to count + inflight - pop < 2 without going negative.
   assign credit_ok = occupancy < (3'd2 + {2'b00, pop});
   assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
   assign drained   = !inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));
   assign flags_d   = {(x_q == '0) && (y_q == '0), x_q == X_LAST, last_pix};

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      addr_d  = addr_q;
      issue   = 1'b0;
      done_d  = 1'b0;
`ifdef FRAME_LOOP_EN
      stop_d  = stop_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               x_d     = '0;
               y_d     = '0;
               addr_d  = '0;
`ifdef FRAME_LOOP_EN
               stop_d  = 1'b0;
`endif
            end
         end
         RUN: begin
`ifdef FRAME_LOOP_EN
            if (stop) begin
               stop_d = 1'b1;
            end
`endif
            if (credit_ok) begin
               issue = 1'b1;
               if (last_pix) begin
                  x_d    = '0;
                  y_d    = '0;
                  addr_d = '0;
`ifdef FRAME_LOOP_EN
                  if (stop_q || stop) begin
                     state_d = DRAIN;
                  end
`else
                  state_d = DRAIN;
`endif
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  if (x_q == X_LAST) begin
                     x_d = '0;
                     y_d = y_q + Y_W'(1);
                  end else begin
                     x_d = x_q + X_W'(1);
                  end
               end
            end
         end
         DRAIN: begin
            if (drained) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef FRAME_LOOP_EN
         stop_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         addr_q     <= addr_d;
         inflight_q <= issue;
         done_q     <= done_d;
`ifdef FRAME_LOOP_EN
         stop_q     <= stop_d;
`endif
      end
   end

   // Flags ride one cycle behind the read so they line up with returning mem_data.
   always_ff @(posedge clk) begin
      if (issue) begin
         flags_q <= flags_d;
      end
   end

   always_comb begin
      push_beat      = '0;
      push_beat.data = mem_data;
      push_beat.sof  = flags_q[2];
      push_beat.eol  = flags_q[1];
      push_beat.eof  = flags_q[0];
   end

   pix_fifo2 u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .push_i  (inflight_q),
      .pop_i   (pop),
      .din_i   (push_beat),
      .dout_o  (head_beat),
      .count_o (fifo_count),
      .full_o  (fifo_full_unused),
      .empty_o (fifo_empty)
   );

   assign mem_en    = issue;
   assign mem_addr  = addr_q;
   assign pix_valid = !fifo_empty;
   assign pix_out   = pix_valid ? head_beat.data : '0;
   assign sof       = pix_valid & head_beat.sof;
   assign eol       = pix_valid & head_beat.eol;
   assign eof       = pix_valid & head_beat.eof;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader on a 4x2 frame: expected raster stream kept as a queue of beat indices.
module tb_frame_reader;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int N  = H * V;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          pix_ready = 1'b0;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [23:0]   mem_data = '0;
   logic [23:0]   pix_out;
   logic          pix_valid, sof, eol, eof, busy, done;

   int            n_vec = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            t0 = 0;
   int            exp_q[$];
   int            issued = 0;
   int            accepted = 0;
   int            n_done = 0, n_sof = 0, n_eol = 0, n_eof = 0;
   int            first_c = -1, eof_c = -1, done_c = -1;
   bit            hold_prev = 1'b0;
   logic [26:0]   prev_word = '0;

   frame_reader #(.H_PIX(H), .V_PIX(V), .ADDR_W(AW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .stop      (stop),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .pix_out   (pix_out),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .sof       (sof),
      .eol       (eol),
      .eof       (eof),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // BRAM model: each word holds its own address, one cycle read latency.
   always @(posedge clk) if (mem_en) mem_data <= 24'(mem_addr);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc - t0);
      end
   endtask

   task automatic compare_cycle();
      int idx;
      bit pop;
      pop = pix_valid && pix_ready;
      if (mem_en) begin
         check("rd_addr", 64'(mem_addr), 64'(issued % N));
         check("rd_ahead", 64'((issued + 1 - accepted - int'(pop)) <= 2), 64'(1));
         issued++;
      end
      if (pix_valid) begin
         if (hold_prev) check("hold", 64'({pix_out, sof, eol, eof}), 64'(prev_word));
         if (exp_q.size() == 0) begin
            check("extra_beat", 64'(pix_valid), 64'(0));
         end else begin
            idx = exp_q[0];
            check("pix", 64'(pix_out), 64'(idx % N));
            check("sof", 64'(sof), 64'(idx % N == 0));
            check("eol", 64'(eol), 64'(idx % H == H - 1));
            check("eof", 64'(eof), 64'(idx % N == N - 1));
            if (pop) begin
               void'(exp_q.pop_front());
               accepted++;
               if (sof) begin
                  n_sof++;
                  if (first_c < 0) first_c = cyc;
               end
               if (eol) n_eol++;
               if (eof) begin
                  n_eof++;
                  eof_c = cyc;
               end
            end
         end
      end else if (hold_prev) begin
         check("valid_drop", 64'(pix_valid), 64'(1));
      end
      hold_prev = pix_valid && !pix_ready;
      prev_word = {pix_out, sof, eol, eof};
      if (done) begin
         n_done++;
         done_c = cyc;
         check("done_drained", 64'(exp_q.size()), 64'(0));
         check("busy_at_done", 64'(busy), 64'(0));
      end
      if (!busy) check("idle_quiet", 64'({mem_en, pix_valid}), 64'(0));
   endtask

   task automatic tick();
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input string tag, input int beats, input int stall_lo,
                            input int stall_hi, input bit rnd, input int restart_at,
                            input int stop_at, input int exp_first, input int exp_eof,
                            input int exp_done);
      int b_done, b_sof, b_eol, b_eof;
      for (int i = 0; i < beats; i++) exp_q.push_back(i);
      b_done = n_done; b_sof = n_sof; b_eol = n_eol; b_eof = n_eof;
      first_c = -1; eof_c = -1; done_c = -1;
      t0 = cyc;
      for (int c = 0; c < 2000 && n_done == b_done; c++) begin
         start = (c == 0) || (c == restart_at);
         stop  = (c == stop_at);
         pix_ready = rnd ? 1'($urandom_range(0, 1)) : !(c >= stall_lo && c <= stall_hi);
         @(negedge clk);
         if (c == 1) check({tag, "_run_t1"}, 64'({busy, mem_en, mem_addr}), 64'({2'b11, {AW{1'b0}}}));
         compare_cycle();
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      stop  = 1'b0;
      check({tag, "_done_seen"}, 64'(n_done - b_done), 64'(1));
      if (exp_first >= 0) check({tag, "_first_cyc"}, 64'(first_c - t0), 64'(exp_first));
      if (exp_eof >= 0) check({tag, "_eof_cyc"}, 64'(eof_c - t0), 64'(exp_eof));
      if (exp_done >= 0) check({tag, "_done_cyc"}, 64'(done_c - t0), 64'(exp_done));
      check({tag, "_n_sof"}, 64'(n_sof - b_sof), 64'(beats / N));
      check({tag, "_n_eol"}, 64'(n_eol - b_eol), 64'(beats / H));
      check({tag, "_n_eof"}, 64'(n_eof - b_eof), 64'(beats / N));
      repeat (4) tick();
      check({tag, "_single_done"}, 64'(n_done - b_done), 64'(1));
      check({tag, "_left"}, 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_outs", 64'({mem_en, mem_addr, pix_out, pix_valid, sof, eol, eof, busy, done}), 64'(0));
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (2) tick();

      // Straight frame: pixels on cycles 3..10, done on 11.
      run_frame("plain", N, 1, 0, 1'b0, -1, 1, 3, 10, 11);
      // Consumer stall on cycles 4..7: pixel 1 held, tail pushed out by 4 cycles.
      run_frame("stall", N, 4, 7, 1'b0, -1, 1, 3, 14, 15);
      // A start pulse mid-frame changes nothing.
      run_frame("start_run", N, 1, 0, 1'b0, 5, 1, 3, 10, 11);
      for (int f = 0; f < 3; f++) run_frame("rand", N, 1, 0, 1'b1, -1, 1, -1, -1, -1);

      // Reset during cycle 6 of a frame; the read issued that cycle must not surface.
      for (int i = 0; i < N; i++) exp_q.push_back(i);
      t0 = cyc;
      pix_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      exp_q.delete();
      issued = 0;
      accepted = 0;
      hold_prev = 1'b0;
      @(negedge clk);
      check("rst_mid_outs", 64'({mem_en, mem_addr, pix_out, pix_valid, sof, eol, eof, busy, done}), 64'(0));
      compare_cycle();
      @(posedge clk);
      #1;
      repeat (3) tick();
      run_frame("restart", N, 1, 0, 1'b0, -1, 1, 3, 10, 11);

`ifdef FRAME_LOOP_EN
      // Two frames back-to-back, stop latched during the second.
      run_frame("loop2", 2 * N, 1, 0, 1'b0, -1, 12, 3, 18, 19);
      // Stop early in the first frame: it still completes to eof.
      run_frame("loop_stop", N, 1, 0, 1'b0, -1, 5, 3, 10, 11);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
